// File: rtl/ps2_key_channel_alloc.sv
// PS/2 keyboard receiver with four-voice key allocator.
// Decoded make/break codes drive four scan_code channels (F0 = silent).
module ps2_key_channel_alloc #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code1,
  output logic [7:0] scan_code2,
  output logic [7:0] scan_code3,
  output logic [7:0] scan_code4,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       alloc_full
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] SILENT = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic [FILTER_LEN-1:0] flt_sh;
  logic clk_f;
  logic all_hi;
  logic all_lo;
  logic fall;
  logic bit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      flt_sh   <= '1;
      clk_f    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      flt_sh   <= {flt_sh[FILTER_LEN-2:0], clk_sync[1]};
      if (all_hi)
        clk_f <= 1'b1;
      else if (all_lo)
        clk_f <= 1'b0;
    end
  end

  assign all_hi = &flt_sh;
  assign all_lo = ~|flt_sh;
  assign fall   = clk_f & all_lo;
  assign bit_in = dat_sync[1];

  rx_state_t state;
  rx_state_t state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [7:0] shreg;
  logic [7:0] sh_nxt;
  logic par_bit;
  logic par_nxt;
  logic [TW-1:0] tmo_cnt;
  logic tmo_hit;
  logic rx_fire;
  logic err_fire;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    rx_fire   = 1'b0;
    err_fire  = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!bit_in) begin
            state_nxt = DATA;
            cnt_nxt   = 3'd0;
          end else begin
            err_fire = 1'b1;
          end
        end
        DATA: begin
          sh_nxt  = {bit_in, shreg[7:1]};
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7)
            state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = bit_in;
          state_nxt = STOP;
        end
        STOP: begin
          if (bit_in && (^{shreg, par_bit}))
            rx_fire = 1'b1;
          else
            err_fire = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit && (state != IDLE)) begin
      // stalled keyboard: drop the partial frame
      state_nxt = IDLE;
      err_fire  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= sh_nxt;
      par_bit   <= par_nxt;
      rx_valid  <= rx_fire;
      frame_err <= err_fire;
      if (fall)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (rx_fire)
        rx_byte <= shreg;
    end
  end

  logic [7:0] ch [4];
  logic [7:0] ch_nxt [4];
  logic ext;
  logic ext_nxt;
  logic brk;
  logic brk_nxt;
  logic full_fire;
  logic is_e0;
  logic is_f0;
  logic is_ign;
  logic hit;
  logic any_free;
  logic [1:0] free_idx;

  assign is_e0  = (rx_byte == 8'hE0);
  assign is_f0  = (rx_byte == 8'hF0);
  assign is_ign = (rx_byte == 8'hAA) || (rx_byte == 8'hFA) ||
                  (rx_byte == 8'hEE) || (rx_byte == 8'hFE) ||
                  (rx_byte == 8'h00) || (rx_byte == 8'hFF);

  always_comb begin
    hit      = 1'b0;
    any_free = 1'b0;
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch[i] == rx_byte)
        hit = 1'b1;
      if (ch[i] == SILENT) begin
        any_free = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      ch_nxt[i] = ch[i];
    ext_nxt   = ext;
    brk_nxt   = brk;
    full_fire = 1'b0;
    if (frame_err) begin
      ext_nxt = 1'b0;
      brk_nxt = 1'b0;
    end else if (rx_valid) begin
      unique case (1'b1)
        is_e0: ext_nxt = 1'b1;
        is_f0: brk_nxt = 1'b1;
        is_ign: begin
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end
        default: begin
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
          if (!ext) begin
            if (brk) begin
              for (int i = 0; i < 4; i++)
                if (ch[i] == rx_byte)
                  ch_nxt[i] = SILENT;
            end else if (!hit) begin
              if (any_free)
                ch_nxt[free_idx] = rx_byte;
              else
                full_fire = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        ch[i] <= SILENT;
      ext        <= 1'b0;
      brk        <= 1'b0;
      alloc_full <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        ch[i] <= ch_nxt[i];
      ext        <= ext_nxt;
      brk        <= brk_nxt;
      alloc_full <= full_fire;
    end
  end

  assign scan_code1 = ch[0];
  assign scan_code2 = ch[1];
  assign scan_code3 = ch[2];
  assign scan_code4 = ch[3];

endmodule

// File: tb/tb_ps2_key_channel_alloc.sv
// Bench for ps2_key_channel_alloc: directed scenarios plus random
// key traffic compared against a channel-list reference model.
module tb_ps2_key_channel_alloc;

  localparam int FL   = 8;
  localparam int TO   = 10000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic [7:0] scan_code1;
  logic [7:0] scan_code2;
  logic [7:0] scan_code3;
  logic [7:0] scan_code4;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic frame_err;
  logic alloc_full;

  always #5 clk = ~clk;

  ps2_key_channel_alloc #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .scan_code1(scan_code1),
    .scan_code2(scan_code2),
    .scan_code3(scan_code3),
    .scan_code4(scan_code4),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .alloc_full(alloc_full)
  );

  logic [7:0] sc [4];
  assign sc[0] = scan_code1;
  assign sc[1] = scan_code2;
  assign sc[2] = scan_code3;
  assign sc[3] = scan_code4;

  int checks = 0;
  int passes = 0;
  int n_rx = 0;
  int n_err = 0;
  int n_full = 0;

  always @(negedge clk) begin
    if (rx_valid) n_rx++;
    if (frame_err) n_err++;
    if (alloc_full) n_full++;
  end

  logic [7:0] m_ch [4];
  bit m_ext;
  bit m_brk;
  int e_rx = 0;
  int e_err = 0;
  int e_full = 0;
  logic [7:0] e_last;

  logic [7:0] keys [6] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33};
  logic [7:0] igns [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = 8'hF0;
    m_ext = 0;
    m_brk = 0;
    e_last = 8'h00;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    bit held;
    int free;
    e_rx++;
    e_last = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      held = 0;
      free = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_ch[i] == b) held = 1;
        if (m_ch[i] == 8'hF0 && free < 0) free = i;
      end
      if (!m_ext) begin
        if (m_brk) begin
          for (int i = 0; i < 4; i++)
            if (m_ch[i] == b) m_ch[i] = 8'hF0;
        end else if (!held) begin
          if (free < 0) e_full++;
          else m_ch[free] = b;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic void m_bad();
    e_err++;
    m_ext = 0;
    m_brk = 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == glitch_bit) begin
        tick(5);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(HALF - 8);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(HALF);
  endtask

  task automatic do_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, -1);
    m_byte(b);
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    m_reset();
    tick(2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sc[i] !== 8'hF0)
        $display("FAIL reset_ch%0d got %h want f0", i + 1, sc[i]);
      else passes++;
    end
    checks++;
    if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte got %h want 00", rx_byte);
    else passes++;
    checks++;
    if ({rx_valid, frame_err, alloc_full} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000", {rx_valid, frame_err, alloc_full});
    else passes++;
  endtask

  task automatic test_single();
    do_byte(8'h1C);
    checks++;
    if (rx_byte !== 8'h1C) $display("FAIL t1_rx_byte got %h want 1c", rx_byte);
    else passes++;
    checks++;
    if (n_rx !== 1) $display("FAIL t1_rx_count got %0d want 1", n_rx);
    else passes++;
    checks++;
    if ({scan_code1, scan_code2, scan_code3, scan_code4} !== 32'h1CF0F0F0)
      $display("FAIL t1_channels got %h %h %h %h want 1c f0 f0 f0",
               scan_code1, scan_code2, scan_code3, scan_code4);
    else passes++;
  endtask

  task automatic test_alloc();
    do_byte(8'h1B);
    do_byte(8'h23);
    do_byte(8'h2B);
    do_byte(8'h34);
    checks++;
    if ({scan_code1, scan_code2, scan_code3, scan_code4} !== 32'h1C1B232B)
      $display("FAIL t2_channels got %h %h %h %h want 1c 1b 23 2b",
               scan_code1, scan_code2, scan_code3, scan_code4);
    else passes++;
    checks++;
    if (n_full !== 1) $display("FAIL t2_alloc_full got %0d want 1", n_full);
    else passes++;
  endtask

  task automatic test_release();
    do_byte(8'hF0);
    do_byte(8'h1B);
    checks++;
    if (scan_code2 !== 8'hF0) $display("FAIL t3_release got %h want f0", scan_code2);
    else passes++;
    do_byte(8'h33);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sc[i] !== m_ch[i])
        $display("FAIL t3_ch%0d got %h want %h", i + 1, sc[i], m_ch[i]);
      else passes++;
    end
  endtask

  task automatic test_repeat();
    do_byte(8'h1C);
    do_byte(8'hF0);
    do_byte(8'h42);
    do_byte(8'hE0);
    do_byte(8'h74);
    do_byte(8'hE0);
    do_byte(8'hF0);
    do_byte(8'h74);
    checks++;
    if ({scan_code1, scan_code2, scan_code3, scan_code4} !== 32'h1C33232B)
      $display("FAIL t4_channels got %h %h %h %h want 1c 33 23 2b",
               scan_code1, scan_code2, scan_code3, scan_code4);
    else passes++;
    checks++;
    if (n_full !== e_full) $display("FAIL t4_alloc_full got %0d want %0d", n_full, e_full);
    else passes++;
  endtask

  task automatic test_bad_frame();
    send_frame(8'h2B, 1'b1, 11, -1);
    m_bad();
    tick(4);
    checks++;
    if (n_err !== e_err) $display("FAIL t5_frame_err got %0d want %0d", n_err, e_err);
    else passes++;
    checks++;
    if (n_rx !== e_rx) $display("FAIL t5_rx_count got %0d want %0d", n_rx, e_rx);
    else passes++;
    do_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 11, 4);
    m_byte(8'h1C);
    tick(4);
    checks++;
    if (rx_byte !== 8'h1C) $display("FAIL t5_glitch_byte got %h want 1c", rx_byte);
    else passes++;
    checks++;
    if (scan_code1 !== 8'hF0) $display("FAIL t5_glitch_release got %h want f0", scan_code1);
    else passes++;
    checks++;
    if (n_err !== e_err) $display("FAIL t5_glitch_err got %0d want %0d", n_err, e_err);
    else passes++;
  endtask

  task automatic test_timeout();
    do_byte(8'hF0);
    send_frame(8'h2B, 1'b0, 5, -1);
    tick(TO + 1);
    m_bad();
    checks++;
    if (n_err !== e_err) $display("FAIL t6_timeout_err got %0d want %0d", n_err, e_err);
    else passes++;
    do_byte(8'h2B);
    checks++;
    if (rx_byte !== 8'h2B) $display("FAIL t6_after_byte got %h want 2b", rx_byte);
    else passes++;
    checks++;
    if (scan_code4 !== 8'h2B) $display("FAIL t6_brk_cleared got %h want 2b", scan_code4);
    else passes++;
    do_byte(8'h1C);
    checks++;
    if (scan_code1 !== 8'h1C) $display("FAIL t6_make got %h want 1c", scan_code1);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h34, 1'b0, 6, -1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_reset();
    tick(2);
    checks++;
    if ({scan_code1, scan_code2, scan_code3, scan_code4} !== 32'hF0F0F0F0)
      $display("FAIL t6_reset_channels got %h %h %h %h want f0 x4",
               scan_code1, scan_code2, scan_code3, scan_code4);
    else passes++;
    checks++;
    if (rx_byte !== 8'h00) $display("FAIL t6_reset_rx got %h want 00", rx_byte);
    else passes++;
    do_byte(8'h23);
    checks++;
    if (rx_byte !== 8'h23 || scan_code1 !== 8'h23)
      $display("FAIL t6_post_reset got %h/%h want 23/23", rx_byte, scan_code1);
    else passes++;
  endtask

  task automatic test_random();
    int r;
    logic [7:0] k;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      k = keys[$urandom_range(0, 5)];
      if (r <= 4) do_byte(k);
      else if (r <= 6) begin
        do_byte(8'hF0);
        do_byte(k);
      end else if (r == 7) begin
        do_byte(8'hE0);
        if ($urandom_range(0, 1) == 1) do_byte(8'hF0);
        do_byte(k);
      end else if (r == 8) do_byte(igns[$urandom_range(0, 5)]);
      else begin
        send_frame(k, 1'b1, 11, -1);
        m_bad();
        tick(4);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sc[i] !== m_ch[i])
          $display("FAIL rnd%0d_ch%0d got %h want %h", t, i + 1, sc[i], m_ch[i]);
        else passes++;
      end
      checks++;
      if (n_rx !== e_rx || n_err !== e_err || n_full !== e_full)
        $display("FAIL rnd%0d_counts got %0d/%0d/%0d want %0d/%0d/%0d", t,
                 n_rx, n_err, n_full, e_rx, e_err, e_full);
      else passes++;
      checks++;
      if (rx_byte !== e_last) $display("FAIL rnd%0d_rx_byte got %h want %h", t, rx_byte, e_last);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alloc();
    test_release();
    test_repeat();
    test_bad_frame();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
